// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command responder.
// Contents:
//   OP_POLL    legacy single-status poll opcode (full byte)
//   OP_RD      channel read opcode (high nibble, low nibble = channel)
//   OP_WR      control write opcode (high nibble, low nibble = channel)
//   OP_STREAM  stream-all-channels opcode (full byte)
//   cmdState_e responder FSM states
package spi_cmd_pkg;

  localparam logic [7:0] OP_POLL   = 8'hFF;
  localparam logic [3:0] OP_RD     = 4'h1;
  localparam logic [3:0] OP_WR     = 4'h2;
  localparam logic [7:0] OP_STREAM = 8'h30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    STREAM  = 2'd2
  } cmdState_e;

endpackage

// File: rtl/spi_cs_sync.sv
// Two-flop synchroniser for the raw SPI chip select, with single-cycle
// pulses on the synchronised rising (frame end) and falling (frame start)
// edges. Resets to the deasserted level (CS_n = 1) so that releasing reset
// with the bus idle does not look like an edge.
// Ports:
//   clk_i   in  1  clock
//   rst_ni  in  1  asynchronous active-low reset
//   cs_n_i  in  1  raw chip select, asynchronous
//   cs_n_o  out 1  synchronised chip select
//   rise_o  out 1  one-cycle pulse on synchronised 0->1
//   fall_o  out 1  one-cycle pulse on synchronised 1->0
module spi_cs_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic cs_n_i,
  output logic cs_n_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain plus one delayed copy for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= cs_n_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign cs_n_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_cmd_responder.sv
// Command/response engine behind the byte-level SPI slave. Decodes master
// command bytes into status reads, control register writes and streaming
// reads, and loads one reply byte into the slave TX buffer for every
// accepted received byte, exactly one cycle after that byte's i_RX_DV.
// Ports:
//   i_Clk      in  1            clock (SPI slave clock domain)
//   i_Rst_L    in  1            asynchronous active-low reset
//   i_RX_DV    in  1            received byte valid pulse
//   i_RX_Byte  in  8            received byte
//   i_SPI_CS_n in  1            raw chip select (synchronised here)
//   i_Status   in  NUM_CH*ST_W  packed status channels, ch0 in LSBs
//   o_TX_DV    out 1            reply byte valid pulse
//   o_TX_Byte  out 8            reply byte
//   o_Ctrl     out NUM_CH*8     packed control registers, ch0 in LSBs
//   o_Ctrl_Wr  out NUM_CH       one-hot pulse when a control register updates
//   o_Cmd_Err  out 1            pulse on an illegal command
module spi_cmd_responder
  import spi_cmd_pkg::*;
#(
  parameter int         NUM_CH   = 4,
  parameter int         ST_W     = 2,
  parameter logic [7:0] CTRL_RST = 8'h00,
  parameter logic [7:0] ERR_BYTE = 8'hEE
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_RX_DV,
  input  logic [7:0]             i_RX_Byte,
  input  logic                   i_SPI_CS_n,
  input  logic [NUM_CH*ST_W-1:0] i_Status,
  output logic                   o_TX_DV,
  output logic [7:0]             o_TX_Byte,
  output logic [NUM_CH*8-1:0]    o_Ctrl,
  output logic [NUM_CH-1:0]      o_Ctrl_Wr,
  output logic                   o_Cmd_Err
);

  // Stream index must be able to hold NUM_CH itself (the terminator slot).
  localparam int IDX_W = (NUM_CH < 2) ? 1 : $clog2(NUM_CH + 1);

  cmdState_e             state_q,  state_d;
  logic [IDX_W-1:0]      idx_q,    idx_d;
  logic [3:0]            wrCh_q,   wrCh_d;
  logic                  txDv_q,   txDv_d;
  logic [7:0]            txByte_q, txByte_d;
  logic [NUM_CH*8-1:0]   ctrl_q,   ctrl_d;
  logic [NUM_CH-1:0]     ctrlWr_q, ctrlWr_d;
  logic                  cmdErr_q, cmdErr_d;

  logic csSync;
  logic csRise;
  logic csFall_unused;
  logic rxOk;
  logic chOk;

  spi_cs_sync u_cs_sync (
    .clk_i  (i_Clk),
    .rst_ni (i_Rst_L),
    .cs_n_i (i_SPI_CS_n),
    .cs_n_o (csSync),
    .rise_o (csRise),
    .fall_o (csFall_unused)
  );

  // Zero-extended status of one channel; out-of-range channels read as 0.
  function automatic logic [7:0] pickStatus(input logic [NUM_CH*ST_W-1:0] st, input int ch);
    logic [7:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (c == ch) r[ST_W-1:0] = st[c*ST_W +: ST_W];
    end
    return r;
  endfunction

  function automatic logic [7:0] pickCtrl(input logic [NUM_CH*8-1:0] cr, input int ch);
    logic [7:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (c == ch) r = cr[c*8 +: 8];
    end
    return r;
  endfunction

  // Bytes arriving while the synchronised CS is high belong to no frame.
  // A frame-end pulse only occurs with csSync high, so it also discards
  // any coincident byte.
  assign rxOk = i_RX_DV & ~csSync;
  assign chOk = int'(i_RX_Byte[3:0]) < NUM_CH;

  // Register bank and FSM state; every output is registered so a reply
  // appears exactly one cycle after the byte that produced it.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wrCh_q   <= '0;
      txDv_q   <= 1'b0;
      txByte_q <= '0;
      ctrl_q   <= {NUM_CH{CTRL_RST}};
      ctrlWr_q <= '0;
      cmdErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wrCh_q   <= wrCh_d;
      txDv_q   <= txDv_d;
      txByte_q <= txByte_d;
      ctrl_q   <= ctrl_d;
      ctrlWr_q <= ctrlWr_d;
      cmdErr_q <= cmdErr_d;
    end
  end

  // Command decode, write and stream sequencing.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wrCh_d   = wrCh_q;
    txDv_d   = 1'b0;
    txByte_d = txByte_q;
    ctrl_d   = ctrl_q;
    ctrlWr_d = '0;
    cmdErr_d = 1'b0;

    if (csRise) begin
      state_d = IDLE;
      idx_d   = '0;
      wrCh_d  = '0;
    end else if (rxOk) begin
      txDv_d = 1'b1;
      unique case (state_q)
        IDLE: begin
          if (i_RX_Byte == OP_POLL) begin
            txByte_d = pickStatus(i_Status, 0);
          end else if (i_RX_Byte[7:4] == OP_RD && chOk) begin
            txByte_d = pickStatus(i_Status, int'(i_RX_Byte[3:0]));
          end else if (i_RX_Byte[7:4] == OP_WR && chOk) begin
            txByte_d = pickCtrl(ctrl_q, int'(i_RX_Byte[3:0]));
            wrCh_d   = i_RX_Byte[3:0];
            state_d  = WR_DATA;
          end else if (i_RX_Byte == OP_STREAM) begin
            txByte_d = pickStatus(i_Status, 0);
            idx_d    = IDX_W'(1);
            state_d  = STREAM;
          end else begin
            txByte_d = ERR_BYTE;
            cmdErr_d = 1'b1;
          end
        end
        WR_DATA: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (c == int'(wrCh_q)) begin
              ctrl_d[c*8 +: 8] = i_RX_Byte;
              ctrlWr_d[c]      = 1'b1;
            end
          end
          txByte_d = i_RX_Byte;
          wrCh_d   = '0;
          state_d  = IDLE;
        end
        STREAM: begin
          if (int'(idx_q) >= NUM_CH) begin
            txByte_d = 8'h00;
            idx_d    = '0;
            state_d  = IDLE;
          end else begin
            txByte_d = pickStatus(i_Status, int'(idx_q));
            idx_d    = idx_q + IDX_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  assign o_TX_DV   = txDv_q;
  assign o_TX_Byte = txByte_q;
  assign o_Ctrl    = ctrl_q;
  assign o_Ctrl_Wr = ctrlWr_q;
  assign o_Cmd_Err = cmdErr_q;

endmodule
